// File: rtl/irq_request_latch.sv
// Interrupt request latch: turns request edges into sticky pending bits and presents
// the lowest-index unmasked pending line as a held id with a valid/ack handshake.
module irq_request_latch #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic          ack,
    input  logic          clr_ovf,
    output logic [N-1:0]  pend_o,
    output logic          valid,
    output logic [IW-1:0] id,
    output logic [N-1:0]  ovf,
    output logic [1:0]    state_dbg
);

    // Handshake: valid rises with id and both stay stable until the cycle ack is
    // seen high; that single cycle transfers the request and valid drops next edge.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RETIRE  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   req_q;
    logic [N-1:0]   pending;
    logic [N-1:0]   rise;
    logic [N-1:0]   retire;
    logic [N-1:0]   pending_nxt;
    logic [N-1:0]   new_ovf;

    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // A new edge on a bit always wins over that bit's retire, so a request
    // arriving in the ack cycle is kept rather than flagged as overflow.
    always_comb begin
        rise        = req & ~req_q;
        retire      = '0;
        if (state == PRESENT && ack) retire = N'(1) << id;
        pending_nxt = rise | (pending & ~retire);
        new_ovf     = rise & pending & ~retire;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            pend_o  <= '0;
            ovf     <= '0;
        end else begin
            req_q   <= req;
            pending <= pending_nxt;
            pend_o  <= pending_nxt & ~mask;
            ovf     <= (clr_ovf ? '0 : ovf) | new_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_o != '0) begin
                        id    <= lowest_set(pend_o);
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= RETIRE;
                    end
                end
                RETIRE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: inputs driven and outputs sampled on the
// falling edge, expected values written out by hand per scenario.
module tb_irq_request_latch;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_ovf;
    logic [7:0] pend_o;
    logic       valid;
    logic [2:0] id;
    logic [7:0] ovf;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    irq_request_latch dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .ack       (ack),
        .clr_ovf   (clr_ovf),
        .pend_o    (pend_o),
        .valid     (valid),
        .id        (id),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    task automatic edge_req(input logic [7:0] v);
        req = v;
        cyc();
        req = 8'h00;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mask = 8'h00; ack = 1'b0; clr_ovf = 1'b0;
        cyc(2);
        rst = 1'b0;
        check("rst_pend", pend_o, 8'h00);
        check("rst_valid", {7'd0, valid}, 8'h00);
        check("rst_id", {5'd0, id}, 8'h00);
        check("rst_ovf", ovf, 8'h00);
        check("rst_state", {6'd0, state_dbg}, 8'h00);

        // 1: single edge on line 5
        edge_req(8'h20);
        check("t1_pend", pend_o, 8'h20);
        check("t1_valid_early", {7'd0, valid}, 8'h00);
        cyc();
        check("t1_valid", {7'd0, valid}, 8'h01);
        check("t1_id", {5'd0, id}, 8'h05);
        pulse_ack();
        check("t1_ack_valid", {7'd0, valid}, 8'h00);
        check("t1_ack_pend", pend_o, 8'h00);
        check("t1_retire_state", {6'd0, state_dbg}, 8'h02);
        cyc(2);

        // 2: simultaneous edges, priority order 1, 3, 6
        exp_q.push_back(8'd1); exp_q.push_back(8'd3); exp_q.push_back(8'd6);
        edge_req(8'h4A);
        check("t2_pend", pend_o, 8'h4A);
        cyc();
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("t2_valid", {7'd0, valid}, 8'h01);
            check("t2_id", {5'd0, id}, e);
            pulse_ack();
            check("t2_gap_valid", {7'd0, valid}, 8'h00);
            cyc(2);
        end
        check("t2_done_valid", {7'd0, valid}, 8'h00);
        check("t2_done_pend", pend_o, 8'h00);

        // 3: masked pending line, then unmask
        mask = 8'h10;
        edge_req(8'h10);
        cyc(2);
        check("t3_masked_valid", {7'd0, valid}, 8'h00);
        check("t3_masked_pend", pend_o, 8'h00);
        mask = 8'h00;
        cyc();
        check("t3_unmask_pend", pend_o, 8'h10);
        cyc();
        check("t3_unmask_id", {5'd0, id}, 8'h04);
        check("t3_unmask_valid", {7'd0, valid}, 8'h01);
        pulse_ack();
        cyc(2);
        // mask a line while it is being presented
        edge_req(8'h04);
        cyc();
        check("t3_id2", {5'd0, id}, 8'h02);
        mask = 8'h04;
        cyc();
        check("t3_held_id", {5'd0, id}, 8'h02);
        check("t3_held_valid", {7'd0, valid}, 8'h01);
        pulse_ack();
        check("t3_retired_valid", {7'd0, valid}, 8'h00);
        mask = 8'h00;
        cyc(3);
        check("t3_gone_valid", {7'd0, valid}, 8'h00);
        check("t3_gone_pend", pend_o, 8'h00);

        // 4: overflow, edge in the ack cycle, clear
        edge_req(8'h04);
        cyc();
        check("t4_id", {5'd0, id}, 8'h02);
        edge_req(8'h04);
        check("t4_ovf", ovf, 8'h04);
        check("t4_held_id", {5'd0, id}, 8'h02);
        cyc();
        req = 8'h04; ack = 1'b1;
        cyc();
        req = 8'h00; ack = 1'b0;
        check("t4_ackedge_valid", {7'd0, valid}, 8'h00);
        check("t4_ackedge_pend", pend_o, 8'h04);
        check("t4_ackedge_ovf", ovf, 8'h04);
        cyc(2);
        check("t4_repres_valid", {7'd0, valid}, 8'h01);
        check("t4_repres_id", {5'd0, id}, 8'h02);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("t4_clr_ovf", ovf, 8'h00);
        pulse_ack();
        cyc(2);

        // 5: async reset mid-handshake, req held across release
        edge_req(8'h08);
        cyc();
        check("t5_id", {5'd0, id}, 8'h03);
        edge_req(8'h08);
        check("t5_ovf", ovf, 8'h08);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", {7'd0, valid}, 8'h00);
        check("t5_rst_pend", pend_o, 8'h00);
        check("t5_rst_ovf", ovf, 8'h00);
        req = 8'h01;
        cyc();
        rst = 1'b0;
        cyc();
        check("t5_rel_pend", pend_o, 8'h01);
        check("t5_rel_valid", {7'd0, valid}, 8'h00);
        cyc();
        check("t5_rel_id", {5'd0, id}, 8'h00);
        check("t5_rel_valid2", {7'd0, valid}, 8'h01);
        req = 8'h00;
        pulse_ack();
        cyc(2);
        check("t5_end_valid", {7'd0, valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
